tiny_dnn_seq: RTL and testbench

Command-driven sequencer sitting directly upstream of `tiny_dnn_top`. It owns that block's `write`/`init`/`exec`/`a`/`d` inputs and its `x` output. It turns a valid/ready word stream into weight loads and dot-product runs across all filters. It then streams the per-filter fp32 results back out.

---
 rtl/tiny_dnn_pkg.sv | 30 +++
 rtl/tiny_dnn_seq.sv | 181 ++++++++++++++++++
 tb/tb_tiny_dnn_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_pkg.sv
// Shared constants and types for the tiny_dnn sequencer.
//   F_NUM / F_SIZE     : filter count and weights per filter
//   FILT_W / IDX_W     : array address fields {filter, index}
//   OP_LOAD_W / OP_RUN : cmd_op encodings
//   seq_state_t        : sequencer FSM states
package tiny_dnn_pkg;

  localparam int F_NUM  = 16;
  localparam int F_SIZE = 512;

  localparam int FILT_W = 4;
  localparam int IDX_W  = 9;
  localparam int ADDR_W = FILT_W + IDX_W;
  localparam int LEN_W  = 10;
  localparam int DATA_W = 32;

  localparam logic OP_LOAD_W = 1'b0;
  localparam logic OP_RUN    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_EXEC,
    S_DRAIN,
    S_RADDR,
    S_RDATA
  } seq_state_t;

endpackage

// File: rtl/tiny_dnn_seq.sv
// tiny_dnn_seq: command-driven sequencer in front of the tiny_dnn array.
// Turns a valid/ready fp32 word stream into weight loads (LOAD_W) and
// dot-product runs (RUN), then streams one fp32 result per filter.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   cmd_valid/ready/op/len     : command handshake, op, vector length n
//   s_valid/ready/data         : fp32 input word stream
//   m_valid/ready/data         : fp32 result stream, filter 0 first
//   err                        : sticky illegal-length flag
//   dnn_write/init/exec/a/d    : registered drives into the array
//   dnn_x                      : array result (registered in the array)
module tiny_dnn_seq
  import tiny_dnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              err,
  output logic              dnn_write,
  output logic              dnn_init,
  output logic              dnn_exec,
  output logic [ADDR_W-1:0] dnn_a,
  output logic [DATA_W-1:0] dnn_d,
  input  logic [DATA_W-1:0] dnn_x
);

  seq_state_t        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [FILT_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              dnn_write_q, dnn_write_d;
  logic              dnn_init_q, dnn_init_d;
  logic              dnn_exec_q, dnn_exec_d;
  logic [ADDR_W-1:0] dnn_a_q, dnn_a_d;
  logic [DATA_W-1:0] dnn_d_q, dnn_d_d;

  logic cmd_fire, s_fire, m_fire;
  logic len_ok, last_k, last_filt, last_idx;

  assign cmd_ready = (state_q == S_IDLE);
  assign s_ready   = (state_q == S_LOAD) || (state_q == S_EXEC);
  assign m_valid   = (state_q == S_RDATA);
  assign m_data    = dnn_x;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;

  assign len_ok    = (cmd_len != '0) && (cmd_len <= LEN_W'(F_SIZE));
  assign last_k    = ({1'b0, k_q} == (len_q - LEN_W'(1)));
  assign last_filt = (filt_q == FILT_W'(F_NUM - 1));
  assign last_idx  = (idx_q == FILT_W'(F_NUM - 1));

  assign err       = err_q;
  assign dnn_write = dnn_write_q;
  assign dnn_init  = dnn_init_q;
  assign dnn_exec  = dnn_exec_q;
  assign dnn_a     = dnn_a_q;
  assign dnn_d     = dnn_d_q;

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      k_q         <= '0;
      filt_q      <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      dnn_write_q <= 1'b0;
      dnn_init_q  <= 1'b0;
      dnn_exec_q  <= 1'b0;
      dnn_a_q     <= '0;
      dnn_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      k_q         <= k_d;
      filt_q      <= filt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      dnn_write_q <= dnn_write_d;
      dnn_init_q  <= dnn_init_d;
      dnn_exec_q  <= dnn_exec_d;
      dnn_a_q     <= dnn_a_d;
      dnn_d_q     <= dnn_d_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire && len_ok)
                 state_d = (cmd_op == OP_RUN) ? S_INIT : S_LOAD;
      S_LOAD:  if (s_fire && last_k && last_filt) state_d = S_IDLE;
      S_INIT:  state_d = S_EXEC;
      S_EXEC:  if (s_fire && last_k) state_d = S_DRAIN;
      // The last exec strobe is still on the output register during the
      // first DRAIN cycle; leave only after the all-zero strobe cycle so
      // the array's two-stage accumulate has settled before the first
      // result address is read.
      S_DRAIN: if (!dnn_exec_q) state_d = S_RADDR;
      S_RADDR: state_d = S_RDATA;
      S_RDATA: if (m_fire) state_d = last_idx ? S_IDLE : S_RADDR;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and counters. Strobes default low so every non-accept cycle
  // registers a zero strobe; address/data hold unless overwritten.
  always_comb begin
    len_d       = len_q;
    k_d         = k_q;
    filt_d      = filt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    dnn_write_d = 1'b0;
    dnn_init_d  = 1'b0;
    dnn_exec_d  = 1'b0;
    dnn_a_d     = dnn_a_q;
    dnn_d_d     = dnn_d_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          len_d  = cmd_len;
          k_d    = '0;
          filt_d = '0;
          idx_d  = '0;
          if (!len_ok)                err_d      = 1'b1;
          else if (cmd_op == OP_RUN)  dnn_init_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (s_fire) begin
          dnn_write_d = 1'b1;
          dnn_d_d     = s_data;
          dnn_a_d     = {filt_q, k_q};
          if (last_k) begin
            k_d    = '0;
            filt_d = filt_q + FILT_W'(1);
          end else begin
            k_d    = k_q + IDX_W'(1);
          end
        end
      end
      S_EXEC: begin
        if (s_fire) begin
          dnn_exec_d = 1'b1;
          dnn_d_d    = s_data;
          dnn_a_d    = {FILT_W'(0), k_q};
          k_d        = k_q + IDX_W'(1);
        end
      end
      // Result address is registered on entry to RADDR so the array's
      // registered read lands exactly at RDATA entry.
      S_DRAIN: begin
        if (!dnn_exec_q) dnn_a_d = {IDX_W'(0), idx_q};
      end
      S_RDATA: begin
        if (m_fire && !last_idx) begin
          idx_d   = idx_q + FILT_W'(1);
          dnn_a_d = {IDX_W'(0), idx_q + FILT_W'(1)};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Directed self-checking bench for tiny_dnn_seq. Includes a behavioural
// stand-in for the tiny_dnn array (weight store, two-stage accumulate,
// registered result read) driven by the sequencer's dnn_* outputs.
module tb_tiny_dnn_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [9:0]  cmd_len;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready;
  logic [31:0] m_data;
  logic        err;
  logic        dnn_write, dnn_init, dnn_exec;
  logic [12:0] dnn_a;
  logic [31:0] dnn_d, dnn_x;

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  real din [3];
  int  wmode;

  always #5 clk = ~clk;

  tiny_dnn_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err(err),
    .dnn_write(dnn_write), .dnn_init(dnn_init), .dnn_exec(dnn_exec),
    .dnn_a(dnn_a), .dnn_d(dnn_d), .dnn_x(dnn_x)
  );

  // fp32 <-> real for exactly representable normal values.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    b = {f[31], e, f[22:0], 29'h0};
    return $bitstoreal(b);
  endfunction

  // Array stand-in: exec registered at E0 is captured at E1, summed at E2.
  real         w_mem [16][512];
  real         acc   [16];
  logic        p_vld = 1'b0;
  real         p_d   = 0.0;
  logic [8:0]  p_k   = '0;
  logic [31:0] x_q   = '0;
  assign dnn_x = x_q;

  always @(posedge clk) begin
    if (dnn_write) w_mem[dnn_a[12:9]][dnn_a[8:0]] <= f2r(dnn_d);
    p_vld <= dnn_exec;
    p_d   <= f2r(dnn_d);
    p_k   <= dnn_a[8:0];
    for (int f = 0; f < 16; f++) begin
      if (dnn_init)   acc[f] <= 0.0;
      else if (p_vld) acc[f] <= acc[f] + w_mem[f][p_k] * p_d;
    end
    x_q <= r2f(acc[dnn_a[3:0]]);
  end

  function automatic real wt(input int mode, input int f, input int k);
    if (mode == 0) return 1.0;
    return (k == 0) ? real'(f + 1) : 0.5;
  endfunction

  function automatic logic [31:0] exp_res(input int mode, input int f, input int n);
    real s;
    s = 0.0;
    for (int k = 0; k < n; k++) s = s + din[k] * wt(mode, f, k);
    return r2f(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [9:0] len);
    int wcnt;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    wcnt = 0;
    while (!cmd_ready && wcnt < 20) begin tick; wcnt++; end
    chk("cmd_accept_ready", {31'h0, cmd_ready}, 32'h1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int n, input int mode);
    logic [31:0] v;
    send_cmd(1'b0, 10'(n));
    for (int f = 0; f < 16; f++) begin
      for (int k = 0; k < n; k++) begin
        v = r2f(wt(mode, f, k));
        s_valid = 1'b1;
        s_data  = v;
        tick;
        chk("load_write", {31'h0, dnn_write}, 32'h1);
        chk("load_addr",  {19'h0, dnn_a}, (f << 9) | k);
        chk("load_data",  dnn_d, v);
      end
    end
    s_valid = 1'b0;
    tick;
    chk("load_write_off", {31'h0, dnn_write}, 32'h0);
    chk("load_done_ready", {31'h0, cmd_ready}, 32'h1);
  endtask

  task automatic do_run(input int n, input int gap_k, input int stall_f, input int exp_first);
    int cyc, wcnt;
    logic [31:0] e;
    send_cmd(1'b1, 10'(n));
    chk("init_pulse", {31'h0, dnn_init}, 32'h1);
    chk("init_sready", {31'h0, s_ready}, 32'h0);
    tick;
    chk("init_one_cycle", {31'h0, dnn_init}, 32'h0);
    cyc = 2;
    for (int k = 0; k < n; k++) begin
      if (k == gap_k) begin
        s_valid = 1'b0;
        repeat (2) begin
          tick; cyc++;
          chk("gap_no_exec", {31'h0, dnn_exec}, 32'h0);
        end
      end
      s_valid = 1'b1;
      s_data  = r2f(din[k]);
      tick; cyc++;
      chk("exec_pulse", {31'h0, dnn_exec}, 32'h1);
      chk("exec_data",  dnn_d, r2f(din[k]));
      chk("exec_addr",  {19'h0, dnn_a}, k);
    end
    s_valid = 1'b0;
    wcnt = 0;
    while (!m_valid && wcnt < 50) begin tick; cyc++; wcnt++; end
    chk("first_mvalid_cycle", cyc, exp_first);
    for (int f = 0; f < 16; f++) begin
      wcnt = 0;
      while (!m_valid && wcnt < 10) begin tick; wcnt++; end
      e = exp_res(wmode, f, n);
      chk("result_valid", {31'h0, m_valid}, 32'h1);
      if (f == stall_f) begin
        m_ready = 1'b0;
        repeat (5) begin
          tick;
          chk("stall_valid", {31'h0, m_valid}, 32'h1);
          chk("stall_data", m_data, e);
        end
        m_ready = 1'b1;
      end
      chk("result_data", m_data, e);
      tick;
    end
    chk("run_done_ready", {31'h0, cmd_ready}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1; wmode = 0;
    din[0] = 1.0; din[1] = 2.0; din[2] = 3.0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_s_ready",   {31'h0, s_ready},   32'h0);
    chk("rst_m_valid",   {31'h0, m_valid},   32'h0);
    chk("rst_err",       {31'h0, err},       32'h0);
    chk("rst_write",     {31'h0, dnn_write}, 32'h0);
    chk("rst_init",      {31'h0, dnn_init},  32'h0);
    chk("rst_exec",      {31'h0, dnn_exec},  32'h0);
    chk("rst_addr",      {19'h0, dnn_a},     32'h0);
    chk("rst_data",      dnn_d,              32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick;

    // Weights all 1.0, n=3.
    do_load(3, 0);
    chk("w_one_enc", r2f(wt(0, 0, 0)), 32'h3F80_0000);

    // 1+2+3 = 6.0 on every filter; first m_valid at cycle n+5.
    do_run(3, -1, -1, 8);
    chk("six_enc", exp_res(0, 0, 3), 32'h40C0_0000);

    // Two-cycle input gap before word 1 and a 5-cycle stall on result 4.
    do_run(3, 1, 4, 10);

    // Illegal lengths: consumed, err set, no array activity.
    send_cmd(1'b0, 10'd0);
    chk("len0_err",    {31'h0, err},       32'h1);
    chk("len0_idle",   {31'h0, cmd_ready}, 32'h1);
    chk("len0_sready", {31'h0, s_ready},   32'h0);
    chk("len0_write",  {31'h0, dnn_write}, 32'h0);
    send_cmd(1'b1, 10'd513);
    chk("len513_err",  {31'h0, err},       32'h1);
    chk("len513_idle", {31'h0, cmd_ready}, 32'h1);
    chk("len513_init", {31'h0, dnn_init},  32'h0);
    tick;
    chk("len513_exec", {31'h0, dnn_exec},  32'h0);

    // Legal commands still work: per-filter weights, n=2.
    wmode = 1;
    din[0] = 1.5; din[1] = 2.0;
    do_load(2, 1);
    do_run(2, -1, -1, 7);
    chk("err_sticky", {31'h0, err}, 32'h1);
    chk("f3_sum_enc", exp_res(1, 3, 2), r2f(7.0));

    // Reset while EXEC is driving an exec strobe.
    send_cmd(1'b1, 10'd2);
    tick;
    s_valid = 1'b1; s_data = r2f(din[0]);
    tick;
    chk("pre_rst_exec", {31'h0, dnn_exec}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_exec",  {31'h0, dnn_exec},  32'h0);
    chk("mid_rst_init",  {31'h0, dnn_init},  32'h0);
    chk("mid_rst_write", {31'h0, dnn_write}, 32'h0);
    chk("mid_rst_sready",{31'h0, s_ready},   32'h0);
    chk("mid_rst_idle",  {31'h0, cmd_ready}, 32'h1);
    chk("mid_rst_err",   {31'h0, err},       32'h0);
    s_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick;
    do_run(2, -1, -1, 7);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", npass, nchk);
    $fatal(1, "timeout");
  end

endmodule
